// File: rtl/seg_refresh.sv
// rtl/seg_refresh.sv - periodic 8-digit 7-segment frame builder feeding a p2s serial shifter
//
// Purpose: encodes 8 hex digits (with decimal points and blank flags) into a
// 64-bit active-low segment frame. The frame is latched onto seg_data every
// REFRESH_DIV cycles, or sooner on an update request. Each latch is followed by
// a SYNC_WIDTH-cycle sync pulse and then HOLD_CYCLES cycles during which the bus
// stays frozen, so that the downstream 64-bit serial transfer completes.
//
// Ports:
//   clk       in   1   system clock, shared with p2s
//   rst       in   1   synchronous active-high reset
//   hex_in    in   32  digit i = hex_in[4i+3:4i], digit 7 leftmost
//   point_in  in   8   decimal point enables, one per digit
//   blank_in  in   8   blank flags; a blanked digit is fully off, point included
//   update    in   1   single-cycle request for an immediate refresh
//   seg_data  out  64  byte i = {dp,g,f,e,d,c,b,a} of digit i, active-low
//   sync      out  1   p2s start strobe (p2s starts on its rising edge)
//   busy      out  1   high while a frame is being loaded, pulsed or held

module seg_refresh #(
    parameter int REFRESH_DIV = 100000,
    parameter int SYNC_WIDTH  = 2,
    parameter int HOLD_CYCLES = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] hex_in,
    input  logic [7:0]  point_in,
    input  logic [7:0]  blank_in,
    input  logic        update,
    output logic [63:0] seg_data,
    output logic        sync,
    output logic        busy
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int PW = $clog2(HOLD_CYCLES + SYNC_WIDTH + 1);

    localparam logic [CW-1:0] CNT_MAX    = CW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(SYNC_WIDTH - 1);
    localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] phase;
    logic          update_pending;
    logic          refresh_due;
    logic          enter_load;
    logic [63:0]   frame;
    logic [7:0]    code;

    function automatic logic [7:0] digit_code(input logic [3:0] d);
        case (d)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    // Frame encoder: blank overrides both the digit and its point.
    always_comb begin
        frame = '1;
        code  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            code    = digit_code(hex_in[4*i +: 4]);
            code[7] = code[7] & ~point_in[i];
            if (blank_in[i]) begin
                code = 8'hFF;
            end
            frame[8*i +: 8] = code;
        end
    end

    assign refresh_due = update_pending || (cnt == CNT_MAX);

    // The final HOLD cycle may hand over straight to LOAD, so a request that
    // arrived during a transfer is served the cycle after HOLD ends.
    assign enter_load = refresh_due &&
                        ((state == IDLE) || (state == HOLD && phase == HOLD_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            seg_data       <= '1;
            sync           <= 1'b0;
            busy           <= 1'b0;
            cnt            <= '0;
            phase          <= '0;
            update_pending <= 1'b1;
        end else begin
            if (enter_load) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end

            // A request coinciding with entry to LOAD or with the LOAD cycle
            // itself is already covered by that frame.
            if (enter_load || state == LOAD) begin
                update_pending <= 1'b0;
            end else if (update) begin
                update_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    sync <= 1'b0;
                end
                LOAD: begin
                    state <= PULSE;
                    sync  <= 1'b1;
                    busy  <= 1'b1;
                    phase <= '0;
                end
                PULSE: begin
                    if (phase == PULSE_LAST) begin
                        state <= HOLD;
                        sync  <= 1'b0;
                        phase <= '0;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                HOLD: begin
                    if (phase == HOLD_LAST) begin
                        phase <= '0;
                        if (!enter_load) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    sync  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            // Outputs of LOAD are registered on entry, so seg_data is valid a
            // full cycle before sync rises.
            if (enter_load) begin
                state    <= LOAD;
                seg_data <= frame;
                sync     <= 1'b0;
                busy     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_refresh.sv
// tb/tb_seg_refresh.sv - self-checking bench for seg_refresh
//
// Purpose: drives seg_refresh with directed and random stimulus and checks
// its outputs against a frame/timing reference model. A serial receiver
// model samples seg_data one bit per cycle, MSB first, from the sync rise.
// Ports: none (top-level bench).

module tb_seg_refresh;

    localparam int RD = 200;
    localparam int SW = 2;
    localparam int HC = 72;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hex_in = '0;
    logic [7:0]  point_in = '0;
    logic [7:0]  blank_in = '0;
    logic        update = 1'b0;
    logic [63:0] seg_data;
    logic        sync;
    logic        busy;

    seg_refresh #(.REFRESH_DIV(RD), .SYNC_WIDTH(SW), .HOLD_CYCLES(HC)) dut (
        .clk      (clk),
        .rst      (rst),
        .hex_in   (hex_in),
        .point_in (point_in),
        .blank_in (blank_in),
        .update   (update),
        .seg_data (seg_data),
        .sync     (sync),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic sync_prev = 1'b0;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        sync_prev <= sync;
    end

    int errors = 0;
    int checks = 0;

    logic [7:0] codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [63:0] ref_frame(input logic [31:0] h, input logic [7:0] p,
                                              input logic [7:0] b);
        logic [63:0] f;
        logic [7:0]  v;
        int          d;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            d = int'((h >> (4 * i)) & 32'hF);
            v = codes[d];
            if (p[i]) v = v & 8'h7F;
            if (b[i]) v = 8'hFF;
            f = f | (64'(v) << (8 * i));
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_rise(output int r);
        r = -1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (sync === 1'b1 && sync_prev === 1'b0) begin
                r = cyc;
                break;
            end
        end
        if (r < 0) chk("rise_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_fall(output int f);
        f = -1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (sync === 1'b0 && sync_prev === 1'b1) begin
                f = cyc;
                break;
            end
        end
        if (f < 0) chk("fall_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int          nb, ns, lc, r, r1, r2, r3, f, rx, rn, rp, kc, busy_low;
        logic [63:0] exp_f, cur_exp, word;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_sync", 64'(sync), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // First frame right after release
        hex_in = 32'h01234567;
        rst    = 1'b0;
        @(negedge clk);
        chk("first_busy", 64'(busy), 64'd1);
        chk("first_sync", 64'(sync), 64'd0);
        chk("first_seg", seg_data, 64'hC0F9A4B0999282F8);
        chk("first_model", seg_data, ref_frame(hex_in, point_in, blank_in));
        nb = 1;
        ns = 0;
        repeat (79) begin
            @(negedge clk);
            nb += int'(busy);
            ns += int'(sync);
        end
        chk("busy_len", 64'(nb), 64'(1 + SW + HC));
        chk("sync_len", 64'(ns), 64'(SW));

        // Points, blanks and an update request
        hex_in   = 32'h89ABCDEF;
        point_in = 8'h01;
        blank_in = 8'h80;
        update   = 1'b1;
        @(negedge clk);
        update = 1'b0;
        @(negedge clk);
        lc = cyc;
        chk("upd_busy", 64'(busy), 64'd1);
        chk("byte7", 64'(seg_data[63:56]), 64'hFF);
        chk("byte6", 64'(seg_data[55:48]), 64'h90);
        chk("byte0", 64'(seg_data[7:0]), 64'h0E);
        exp_f = ref_frame(hex_in, point_in, blank_in);
        chk("upd_model", seg_data, exp_f);

        // Steady-state refresh period
        wait_rise(r1);
        chk("rise_after_load", 64'(r1), 64'(lc + 1));
        wait_rise(r2);
        chk("period1", 64'(r2 - r1), 64'(RD));
        chk("frame_stable", seg_data, exp_f);
        wait_rise(r3);
        chk("period2", 64'(r3 - r2), 64'(RD));

        // Update 5 cycles into HOLD, plus a second one in the resulting LOAD
        wait_fall(f);
        repeat (5) @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update   = 1'b0;
        busy_low = 0;
        while (cyc < f + HC) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_low++;
        end
        chk("hold_busy_low", 64'(busy_low), 64'd0);
        chk("xload_busy", 64'(busy), 64'd1);
        chk("xload_sync", 64'(sync), 64'd0);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        chk("xload_rise", 64'(sync), 64'd1);
        rx = f + HC + 1;
        wait_rise(rn);
        chk("no_extra_frame", 64'(rn - rx), 64'(RD));

        // Reset during PULSE
        wait_rise(r);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sync", 64'(sync), 64'd0);
        chk("abort_seg", seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("abort_busy", 64'(busy), 64'd0);
        rst    = 1'b0;
        hex_in = $urandom;
        @(negedge clk);
        lc = cyc;
        chk("post_rst_seg", seg_data, ref_frame(hex_in, point_in, blank_in));
        wait_rise(r);
        chk("post_rst_rise", 64'(r), 64'(lc + 1));

        // 100 random frames through a serial receiver model
        cur_exp = ref_frame(hex_in, point_in, blank_in);
        rp      = r;
        for (int k = 0; k < 100; k++) begin
            wait_rise(r);
            if (k > 0) chk("no_overlap", 64'((r - rp) >= (1 + SW + HC)), 64'd1);
            rp   = r;
            kc   = int'($urandom_range(63, 0));
            word = '0;
            for (int i = 0; i < 64; i++) begin
                if (i > 0) @(negedge clk);
                word = {word[62:0], seg_data[63 - i]};
                if (i == kc) begin
                    hex_in   = $urandom;
                    point_in = 8'($urandom);
                    blank_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
                end
            end
            chk("serial_frame", word, cur_exp);
            cur_exp = ref_frame(hex_in, point_in, blank_in);
            if ($urandom_range(1, 0) == 1) begin
                update = 1'b1;
                @(negedge clk);
                update = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
